// File: rtl/vehicle_actuator_model.sv
// Plant model for the self-driving decision FSM: own speed, gap to the lead car, door-lock actuator.
// Latency: state and outputs update on the clk edge of a physics tick (every TICK_DIV cycles); lock_busy rises/aborts on any edge.
// Backpressure: none; commands are levels sampled on ticks, an unlock request is refused while the car moves.
module vehicle_actuator_model #(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned ACCEL_STEP = 2,
    parameter int unsigned COAST_STEP = 1,
    parameter int unsigned BRAKE_STEP = 4,
    parameter int unsigned MAX_SPEED  = 200,
    parameter int unsigned BRAKE_DIST = 20,
    parameter int unsigned INIT_DIST  = 100,
    parameter int unsigned LOCK_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       accelerate_car,
    input  logic       door_locked,
    input  logic [7:0] lead_speed,
    output logic [7:0] car_speed,
    output logic [6:0] leading_distance,
    output logic       door_state,
    output logic       lock_busy,
    output logic       collision
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LT_W  = $clog2(LOCK_DELAY + 1);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_ACCEL,
        ST_COAST,
        ST_BRAKE
    } speed_state_t;

    speed_state_t state, state_nxt;

    logic [CNT_W-1:0] presc_cnt;
    logic             tick;

    logic [LT_W-1:0]  lock_timer;
    logic             lock_start;
    logic             lock_abort;

    logic signed [9:0] speed_diff;
    logic signed [9:0] gap_delta;
    logic signed [9:0] gap_raw;
    logic [6:0]        gap_clamped;
    logic              collision_hit;
    logic              brake_cond;

    logic [8:0] speed_up;
    logic [7:0] accel_speed;
    logic [7:0] coast_speed;
    logic [7:0] brake_speed;
    logic [7:0] speed_nxt;

    assign tick = (presc_cnt == CNT_W'(TICK_DIV - 1));

    // Free-running prescaler that marks one physics tick every TICK_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + CNT_W'(1);
        end
    end

    // Gap integrator: relative speed scaled by 1/16, floored (arithmetic shift), using pre-update speed.
    assign speed_diff = $signed({2'b00, lead_speed}) - $signed({2'b00, car_speed});
    assign gap_delta  = speed_diff >>> 4;
    assign gap_raw    = $signed({3'b000, leading_distance}) + gap_delta;

    // Clamp the integrated gap into the 7-bit output range.
    always_comb begin
        gap_clamped = gap_raw[6:0];
        if (gap_raw < 10'sd0) begin
            gap_clamped = 7'd0;
        end else if (gap_raw > 10'sd127) begin
            gap_clamped = 7'd127;
        end
    end

    // A moving car whose gap would reach zero or below has hit the lead vehicle.
    assign collision_hit = (gap_raw <= 10'sd0) && (car_speed != 8'd0);
    assign brake_cond    = (leading_distance < 7'(BRAKE_DIST)) && (car_speed != 8'd0);

    // Saturating speed actions for each moving state.
    assign speed_up    = {1'b0, car_speed} + 9'(ACCEL_STEP);
    assign accel_speed = (speed_up > {1'b0, 8'(MAX_SPEED)}) ? 8'(MAX_SPEED) : speed_up[7:0];
    assign coast_speed = (car_speed > 8'(COAST_STEP)) ? (car_speed - 8'(COAST_STEP)) : 8'd0;
    assign brake_speed = (car_speed > 8'(BRAKE_STEP)) ? (car_speed - 8'(BRAKE_STEP)) : 8'd0;

    // Speed FSM: action of the current state plus next state; collision beats braking beats commands.
    always_comb begin
        state_nxt = state;
        speed_nxt = car_speed;

        case (state)
            ST_ACCEL: speed_nxt = accel_speed;
            ST_COAST: speed_nxt = coast_speed;
            ST_BRAKE: speed_nxt = brake_speed;
            default:  speed_nxt = car_speed;
        endcase
        if (collision) begin
            speed_nxt = 8'd0;
        end

        if (collision || collision_hit) begin
            state_nxt = ST_STOPPED;
        end else if (brake_cond) begin
            state_nxt = ST_BRAKE;
        end else begin
            case (state)
                ST_STOPPED: begin
                    if (accelerate_car && door_state && !lock_busy) begin
                        state_nxt = ST_ACCEL;
                    end
                end
                ST_ACCEL: begin
                    if (!accelerate_car) begin
                        state_nxt = ST_COAST;
                    end
                end
                ST_COAST: begin
                    if (accelerate_car) begin
                        state_nxt = ST_ACCEL;
                    end else if (car_speed == 8'd0) begin
                        state_nxt = ST_STOPPED;
                    end
                end
                ST_BRAKE: begin
                    if (car_speed == 8'd0) begin
                        state_nxt = ST_STOPPED;
                    end else if (leading_distance >= 7'(BRAKE_DIST)) begin
                        state_nxt = ST_COAST;
                    end
                end
                default: state_nxt = ST_STOPPED;
            endcase
        end
    end

    // Physics registers: advance speed, gap, FSM state and the sticky crash flag on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_STOPPED;
            car_speed        <= 8'd0;
            leading_distance <= 7'(INIT_DIST);
            collision        <= 1'b0;
        end else if (tick) begin
            state            <= state_nxt;
            car_speed        <= speed_nxt;
            leading_distance <= gap_clamped;
            collision        <= collision | collision_hit;
        end
    end

    // Door requests: unlocking a moving car is refused; returning to the current position aborts travel.
    assign lock_start = !lock_busy && (door_locked != door_state) && (door_locked || (car_speed == 8'd0));
    assign lock_abort = lock_busy && (door_locked == door_state);

    // Door actuator: travel starts on any edge, completes after LOCK_DELAY ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            door_state <= 1'b1;
            lock_busy  <= 1'b0;
            lock_timer <= '0;
        end else if (lock_abort) begin
            lock_busy  <= 1'b0;
            lock_timer <= '0;
        end else if (lock_start) begin
            lock_busy  <= 1'b1;
            lock_timer <= '0;
        end else if (lock_busy && tick) begin
            if (lock_timer == LT_W'(LOCK_DELAY - 1)) begin
                door_state <= door_locked;
                lock_busy  <= 1'b0;
                lock_timer <= '0;
            end else begin
                lock_timer <= lock_timer + LT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vehicle_actuator_model.sv
// Bench for vehicle_actuator_model: directed scenarios against an arithmetic plant model plus literal checkpoints.
// Latency: model and DUT compared 1 time unit after every rising clk edge.
// Backpressure: none; the second instance covers the crash scenario with a short initial gap.
module tb_vehicle_actuator_model;

    localparam int TD = 4;
    localparam int AS = 2;
    localparam int CS = 1;
    localparam int BS = 4;
    localparam int MS = 200;
    localparam int BD = 20;
    localparam int ID = 100;
    localparam int LD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       accelerate_car = 1'b0;
    logic       door_locked = 1'b1;
    logic [7:0] lead_speed = 8'd0;
    logic [7:0] car_speed;
    logic [6:0] leading_distance;
    logic       door_state;
    logic       lock_busy;
    logic       collision;

    logic       c_rst = 1'b1;
    logic       c_acc = 1'b1;
    logic       c_door_locked = 1'b1;
    logic [7:0] c_lead = 8'd0;
    logic [7:0] c_speed;
    logic [6:0] c_gap;
    logic       c_door;
    logic       c_busy;
    logic       c_coll;

    int n_checks = 0;
    int n_fail   = 0;

    vehicle_actuator_model #(
        .TICK_DIV(TD), .ACCEL_STEP(AS), .COAST_STEP(CS), .BRAKE_STEP(BS),
        .MAX_SPEED(MS), .BRAKE_DIST(BD), .INIT_DIST(ID), .LOCK_DELAY(LD)
    ) dut (
        .clk(clk), .rst(rst), .accelerate_car(accelerate_car), .door_locked(door_locked),
        .lead_speed(lead_speed), .car_speed(car_speed), .leading_distance(leading_distance),
        .door_state(door_state), .lock_busy(lock_busy), .collision(collision)
    );

    vehicle_actuator_model #(
        .TICK_DIV(TD), .ACCEL_STEP(AS), .COAST_STEP(CS), .BRAKE_STEP(BS),
        .MAX_SPEED(MS), .BRAKE_DIST(0), .INIT_DIST(10), .LOCK_DELAY(LD)
    ) dut_crash (
        .clk(clk), .rst(c_rst), .accelerate_car(c_acc), .door_locked(c_door_locked),
        .lead_speed(c_lead), .car_speed(c_speed), .leading_distance(c_gap),
        .door_state(c_door), .lock_busy(c_busy), .collision(c_coll)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural plant model ----------------
    typedef enum int {M_STOPPED, M_ACCEL, M_COAST, M_BRAKE} mode_t;
    mode_t m_mode;
    int    m_speed, m_gap, m_door, m_busy, m_coll, m_phase, m_travel, m_ticks;

    function automatic int floor_div16(input int d);
        int r;
        r = d % 16;
        if (r < 0) r = r + 16;
        return (d - r) / 16;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk or posedge rst) begin : plant_model
        int    raw, nspeed, ngap, ncoll, ndoor, nbusy, ntravel;
        mode_t nmode;
        bit    tk;
        if (rst) begin
            m_mode   <= M_STOPPED;
            m_speed  <= 0;
            m_gap    <= ID;
            m_door   <= 1;
            m_busy   <= 0;
            m_coll   <= 0;
            m_phase  <= 0;
            m_travel <= 0;
            m_ticks  <= 0;
        end else begin
            tk      = (m_phase == TD - 1);
            nspeed  = m_speed;
            ngap    = m_gap;
            ncoll   = m_coll;
            nmode   = m_mode;
            ndoor   = m_door;
            nbusy   = m_busy;
            ntravel = m_travel;

            if (m_busy == 1 && int'(door_locked) == m_door) begin
                nbusy = 0;
                ntravel = 0;
            end else if (m_busy == 0 && int'(door_locked) != m_door && (door_locked || m_speed == 0)) begin
                nbusy = 1;
                ntravel = 0;
            end else if (m_busy == 1 && tk) begin
                ntravel = m_travel + 1;
                if (ntravel == LD) begin
                    ndoor = int'(door_locked);
                    nbusy = 0;
                    ntravel = 0;
                end
            end

            if (tk) begin
                raw   = m_gap + floor_div16(int'(lead_speed) - m_speed);
                ngap  = imin(imax(raw, 0), 127);
                ncoll = (m_coll == 1 || (raw <= 0 && m_speed != 0)) ? 1 : 0;
                if (m_coll == 1) nspeed = 0;
                else if (m_mode == M_ACCEL) nspeed = imin(m_speed + AS, MS);
                else if (m_mode == M_COAST) nspeed = imax(m_speed - CS, 0);
                else if (m_mode == M_BRAKE) nspeed = imax(m_speed - BS, 0);
                if (ncoll == 1) nmode = M_STOPPED;
                else if (m_gap < BD && m_speed != 0) nmode = M_BRAKE;
                else if (m_mode == M_STOPPED && accelerate_car && m_door == 1 && m_busy == 0) nmode = M_ACCEL;
                else if (m_mode == M_ACCEL && !accelerate_car) nmode = M_COAST;
                else if (m_mode == M_COAST && accelerate_car) nmode = M_ACCEL;
                else if (m_mode == M_COAST && m_speed == 0) nmode = M_STOPPED;
                else if (m_mode == M_BRAKE && m_speed == 0) nmode = M_STOPPED;
                else if (m_mode == M_BRAKE && m_gap >= BD) nmode = M_COAST;
                m_ticks <= m_ticks + 1;
            end

            m_phase  <= (m_phase + 1) % TD;
            m_mode   <= nmode;
            m_speed  <= nspeed;
            m_gap    <= ngap;
            m_coll   <= ncoll;
            m_door   <= ndoor;
            m_busy   <= nbusy;
            m_travel <= ntravel;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(posedge clk) begin
        #1;
        check("model car_speed", int'(car_speed), m_speed);
        check("model leading_distance", int'(leading_distance), m_gap);
        check("model door_state", int'(door_state), m_door);
        check("model lock_busy", int'(lock_busy), m_busy);
        check("model collision", int'(collision), m_coll);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_tick(input int k);
        int guard;
        guard = 0;
        while (m_ticks < k) begin
            @(posedge clk);
            #2;
            guard++;
            if (guard > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_tick timeout: reached tick %0d, wanted %0d", m_ticks, k);
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset car_speed", int'(car_speed), 0);
        check("reset leading_distance", int'(leading_distance), 100);
        check("reset door_state", int'(door_state), 1);
        check("reset lock_busy", int'(lock_busy), 0);
        check("reset collision", int'(collision), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset from power-up.
        do_reset();

        // Accelerate behind a fast lead car.
        accelerate_car = 1'b1; lead_speed = 8'd200; door_locked = 1'b1;
        wait_tick(1);   check("accel tick1 speed", int'(car_speed), 0);
        wait_tick(6);   check("accel tick6 speed", int'(car_speed), 10);
        wait_tick(101); check("accel tick101 speed", int'(car_speed), 200);
        wait_tick(105); check("accel hold speed", int'(car_speed), 200);
        check("accel gap clamp", int'(leading_distance), 127);

        // Reset mid-operation.
        do_reset();

        // Coast down from 10.
        accelerate_car = 1'b1; lead_speed = 8'd200;
        wait_tick(5);
        @(negedge clk); accelerate_car = 1'b0;
        wait_tick(6);  check("coast entry speed", int'(car_speed), 10);
        wait_tick(7);  check("coast first step", int'(car_speed), 9);
        wait_tick(16); check("coast reaches 0", int'(car_speed), 0);
        wait_tick(20); check("coast stays stopped", int'(car_speed), 0);

        // Auto-brake toward a stationary lead car (ends in a crash).
        do_reset();
        accelerate_car = 1'b1; lead_speed = 8'd0;
        wait_tick(35); check("brake t35 speed", int'(car_speed), 68);
        check("brake t35 gap", int'(leading_distance), 15);
        wait_tick(36); check("brake t36 speed", int'(car_speed), 70);
        check("brake t36 gap", int'(leading_distance), 10);
        wait_tick(37); check("brake t37 speed", int'(car_speed), 66);
        check("brake t37 gap", int'(leading_distance), 5);
        wait_tick(38); check("brake t38 speed", int'(car_speed), 62);
        check("brake t38 collision", int'(collision), 1);
        wait_tick(39); check("brake t39 forced stop", int'(car_speed), 0);

        // Door actuator.
        do_reset();
        accelerate_car = 1'b1; lead_speed = 8'd200; door_locked = 1'b1;
        wait_tick(16); check("door speed 30", int'(car_speed), 30);
        @(negedge clk); door_locked = 1'b0;
        wait_tick(18);
        check("door refused busy", int'(lock_busy), 0);
        check("door refused state", int'(door_state), 1);
        @(negedge clk); accelerate_car = 1'b0;
        wait_tick(55); check("door coast to 0", int'(car_speed), 0);
        wait_tick(56); check("door travel busy", int'(lock_busy), 1);
        check("door travel state", int'(door_state), 1);
        wait_tick(58); check("door unlocked", int'(door_state), 0);
        check("door unlocked idle", int'(lock_busy), 0);
        @(negedge clk); accelerate_car = 1'b1;
        wait_tick(64); check("door open no accel", int'(car_speed), 0);
        @(negedge clk); door_locked = 1'b1;
        wait_tick(65); check("relock busy", int'(lock_busy), 1);
        @(negedge clk); door_locked = 1'b0;
        wait_tick(66); check("abort busy", int'(lock_busy), 0);
        check("abort state", int'(door_state), 0);
        @(negedge clk); door_locked = 1'b1;
        @(posedge clk); #2;
        check("busy before reset", int'(lock_busy), 1);
        do_reset();

        // Crash instance: BRAKE_DIST 0, INIT_DIST 10, lead stopped.
        @(negedge clk); c_rst = 1'b0;
        repeat (40) @(posedge clk); #2;
        check("crash t10 speed", int'(c_speed), 18);
        check("crash t10 gap", int'(c_gap), 2);
        check("crash t10 flag", int'(c_coll), 0);
        repeat (4) @(posedge clk); #2;
        check("crash t11 flag", int'(c_coll), 1);
        check("crash t11 speed", int'(c_speed), 20);
        check("crash t11 gap", int'(c_gap), 0);
        repeat (4) @(posedge clk); #2;
        check("crash t12 speed", int'(c_speed), 0);
        repeat (32) @(posedge clk); #2;
        check("crash sticky", int'(c_coll), 1);
        check("crash stays stopped", int'(c_speed), 0);
        @(negedge clk); c_rst = 1'b1; #1;
        check("crash reset flag", int'(c_coll), 0);
        check("crash reset gap", int'(c_gap), 10);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
